// File: rtl/unsigned_serial_subtractor_24bit.sv
// unsigned_serial_subtractor_24bit
//   Purpose : 24-bit unsigned subtractor that processes CHUNK bits per cycle,
//             LSB slice first, and reports Borrow = (A < B).
//   Latency : N = 24/CHUNK cycles from the accept edge to out_valid. With
//             USUB24_ABS_RESULT_EN defined and A < B, a chunked negation pass
//             is added, so the result then takes 2N cycles.
//   Backpressure: one operation in flight. in_ready is high only in IDLE and
//             the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst         single clock, asynchronous active-high reset
//   in_valid/in_ready, A, B         operand handshake (minuend, subtrahend)
//   out_valid/out_ready, Diff, Borrow  result handshake
//
// Build option:
//   USUB24_ABS_RESULT_EN  when defined, Diff is |A-B| instead of (A-B) mod 2^24.

module unsigned_serial_subtractor_24bit #(
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] A,
  input  logic [23:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] Diff,
  output logic        Borrow
);

  localparam int N = 24 / CHUNK;
  localparam logic [4:0] LAST = 5'(N - 1);
  // Bit position where a freshly computed slice enters the result register.
  localparam int INS = 24 - CHUNK;

  // CHUNK must divide 24 exactly so that every slice is full width.
  if (CHUNK < 1 || CHUNK > 24 || (24 % CHUNK) != 0) begin : g_bad_chunk
    $error("unsigned_serial_subtractor_24bit: CHUNK must divide 24");
  end

`ifdef USUB24_ABS_RESULT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t state;
  state_t state_next;

  // Operand shift registers: the slice being worked on is always in the
  // low CHUNK bits, so the datapath needs no variable-index muxing.
  logic [23:0] a_sh;
  logic [23:0] b_sh;
  // Result register: slices enter at the top and shift down, so after N
  // steps the first (LSB) slice has arrived at bit 0.
  logic [23:0] diff_sh;
  logic        borrow_q;
  logic [4:0]  cnt;
  logic        last;

  // One subtract slice with borrow-in.
  logic [CHUNK-1:0] a_lo;
  logic [CHUNK-1:0] b_lo;
  logic [CHUNK:0]   sub_full;
  logic [23:0]      sub_ins;
  logic             sub_bout;

  assign a_lo     = a_sh[CHUNK-1:0];
  assign b_lo     = b_sh[CHUNK-1:0];
  // The extra MSB of the CHUNK+1 bit difference is the slice borrow-out:
  // the largest underflow is 2^CHUNK, which always lands with that bit set.
  assign sub_full = {1'b0, a_lo} - {1'b0, b_lo} - (CHUNK+1)'(borrow_q);
  assign sub_bout = sub_full[CHUNK];
  assign sub_ins  = 24'(sub_full[CHUNK-1:0]) << INS;
  assign last     = (cnt == LAST);

`ifdef USUB24_ABS_RESULT_EN
  // Two's-complement negation, one slice per cycle: invert and add the
  // running carry, which is seeded with 1 when SUB hands over to NEG.
  logic             carry_q;
  logic [CHUNK-1:0] d_lo;
  logic [CHUNK:0]   neg_full;
  logic [23:0]      neg_ins;

  assign d_lo     = diff_sh[CHUNK-1:0];
  assign neg_full = {1'b0, ~d_lo} + (CHUNK+1)'(carry_q);
  assign neg_ins  = 24'(neg_full[CHUNK-1:0]) << INS;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = SUB;
        end
      end
      SUB: begin
        if (last) begin
`ifdef USUB24_ABS_RESULT_EN
          // The borrow-out of the final slice decides whether the modulo
          // result must be negated to give the magnitude.
          if (sub_bout) begin
            state_next = NEG;
          end else begin
            state_next = DONE;
          end
`else
          state_next = DONE;
`endif
        end
      end
`ifdef USUB24_ABS_RESULT_EN
      NEG: begin
        if (last) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= 24'h000000;
      b_sh     <= 24'h000000;
      diff_sh  <= 24'h000000;
      borrow_q <= 1'b0;
      cnt      <= 5'd0;
`ifdef USUB24_ABS_RESULT_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Operands are captured here; later changes on A/B are ignored.
            a_sh     <= A;
            b_sh     <= B;
            borrow_q <= 1'b0;
            cnt      <= 5'd0;
          end
        end
        SUB: begin
          a_sh     <= a_sh >> CHUNK;
          b_sh     <= b_sh >> CHUNK;
          diff_sh  <= (diff_sh >> CHUNK) | sub_ins;
          // After the last slice this holds the overall borrow, which is
          // exactly the A < B flag presented on Borrow.
          borrow_q <= sub_bout;
          cnt      <= last ? 5'd0 : cnt + 5'd1;
`ifdef USUB24_ABS_RESULT_EN
          carry_q  <= 1'b1;
`endif
        end
`ifdef USUB24_ABS_RESULT_EN
        NEG: begin
          // Borrow is left untouched so it still reports A < B.
          diff_sh <= (diff_sh >> CHUNK) | neg_ins;
          carry_q <= neg_full[CHUNK];
          cnt     <= last ? 5'd0 : cnt + 5'd1;
        end
`endif
        default: begin
          // DONE: hold the result until the consumer takes it.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all driven from registers
  // ---------------------------------------------------------------------
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Diff      = diff_sh;
  assign Borrow    = borrow_q;

endmodule

// File: tb/tb_unsigned_serial_subtractor_24bit.sv
// Directed bench for unsigned_serial_subtractor_24bit: CHUNK=4 and CHUNK=1
// instances, latency/handshake/reset checks and a back-to-back random run.
module tb_unsigned_serial_subtractor_24bit;

  localparam int N4 = 6;
  localparam int N1 = 24;
`ifdef USUB24_ABS_RESULT_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [23:0] A;
  logic [23:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Diff;
  logic        Borrow;

  logic        c1_in_valid;
  logic        c1_in_ready;
  logic [23:0] c1_A;
  logic [23:0] c1_B;
  logic        c1_out_valid;
  logic        c1_out_ready;
  logic [23:0] c1_Diff;
  logic        c1_Borrow;

  int nchecks;
  int nerr;

  unsigned_serial_subtractor_24bit #(.CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Diff(Diff), .Borrow(Borrow)
  );

  unsigned_serial_subtractor_24bit #(.CHUNK(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(c1_in_valid), .in_ready(c1_in_ready), .A(c1_A), .B(c1_B),
    .out_valid(c1_out_valid), .out_ready(c1_out_ready), .Diff(c1_Diff), .Borrow(c1_Borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation on the CHUNK=4 instance with hand-computed raw and |A-B|
  // results. With hold=1 the result is left pending in DONE.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] raw, input logic [23:0] mag,
                        input logic eb, input bit hold);
    int cyc;
    int el;
    el = (ABS && eb) ? 2 * N4 : N4;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a;
    B = ~b;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(el));
    check({tag, "_diff"}, 32'(Diff), 32'(ABS ? mag : raw));
    check({tag, "_brw"}, 32'(Borrow), 32'(eb));
    if (!hold) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  task automatic run_op1(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] raw, input logic [23:0] mag, input logic eb);
    int cyc;
    int el;
    el = (ABS && eb) ? 2 * N1 : N1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(c1_in_ready), 32'd1);
    c1_in_valid = 1'b1;
    c1_A = a;
    c1_B = b;
    @(posedge clk);
    @(negedge clk);
    c1_in_valid = 1'b0;
    cyc = 0;
    while (!c1_out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(el));
    check({tag, "_diff"}, 32'(c1_Diff), 32'(ABS ? mag : raw));
    check({tag, "_brw"}, 32'(c1_Borrow), 32'(eb));
    c1_out_ready = 1'b1;
    @(negedge clk);
    c1_out_ready = 1'b0;
    check({tag, "_idle"}, 32'(c1_in_ready), 32'd1);
  endtask

  initial begin
    logic [23:0] ra;
    logic [23:0] rb;
    logic [23:0] ed;
    logic        eb;
    int          cyc;
    int          el;

    nchecks = 0;
    nerr    = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = 24'h0; B = 24'h0;
    c1_in_valid = 1'b0; c1_out_ready = 1'b0; c1_A = 24'h0; c1_B = 24'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(Diff), 32'h0);
    check("rst_brw", 32'(Borrow), 32'd0);
    check("rst_c1_ovld", 32'(c1_out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_c1_rdy", 32'(c1_in_ready), 32'd1);

    // Directed arithmetic
    run_op("d5m3", 24'h000005, 24'h000003, 24'h000002, 24'h000002, 1'b0, 1'b0);
    run_op("d3m5", 24'h000003, 24'h000005, 24'hFFFFFE, 24'h000002, 1'b1, 1'b0);
    run_op("dripple", 24'h100000, 24'h000001, 24'h0FFFFF, 24'h0FFFFF, 1'b0, 1'b0);
    run_op("dzmax", 24'h000000, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 1'b1, 1'b0);
    run_op("dmaxz", 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    run_op("deq", 24'h123456, 24'h123456, 24'h000000, 24'h000000, 1'b0, 1'b0);

    // Backpressure: result held for 10 cycles while new operands are offered
    run_op("bp", 24'h000003, 24'h000005, 24'hFFFFFE, 24'h000002, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A = 24'h111111;
      B = 24'h000001;
      check("bp_ovld", 32'(out_valid), 32'd1);
      check("bp_rdy", 32'(in_ready), 32'd0);
      check("bp_diff", 32'(Diff), 32'(ABS ? 24'h000002 : 24'hFFFFFE));
      check("bp_brw", 32'(Borrow), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_rdy", 32'(in_ready), 32'd1);
    check("bp_rel_ovld", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_not_taken", 32'(in_ready), 32'd1);

    // Reset in the third SUB cycle of an operation that would borrow
    @(negedge clk);
    in_valid = 1'b1;
    A = 24'h000000;
    B = 24'h000001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ovld", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(Diff), 32'h0);
    check("mid_rst_brw", 32'(Borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 1'b0);

    // CHUNK=1 instance
    run_op1("c1_a", 24'h800000, 24'h000001, 24'h7FFFFF, 24'h7FFFFF, 1'b0);
    run_op1("c1_b", 24'h000001, 24'h000002, 24'hFFFFFF, 24'h000001, 1'b1);

    // Back-to-back random pairs with in_valid and out_ready held high
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        ra = 24'hABCDEF; rb = 24'hABCDEF;
      end else if (i == 1) begin
        ra = 24'h000000; rb = 24'hFFFFFF;
      end else begin
        ra = 24'($urandom);
        rb = 24'($urandom);
      end
      eb = (ra < rb);
      ed = ra - rb;
      if (ABS && eb) ed = rb - ra;
      el = (ABS && eb) ? 2 * N4 : N4;
      check("b2b_rdy", 32'(in_ready), 32'd1);
      A = ra;
      B = rb;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("b2b_lat", 32'(cyc), 32'(el));
      check("b2b_diff", 32'(Diff), 32'(ed));
      check("b2b_brw", 32'(Borrow), 32'(eb));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b_end_rdy", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
